// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC scanner: FSM state codes, pad mask and parameter checks.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package spi_adc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_QUIET = 3'd5;

  // Widest frame the pad-mask helper can describe.
  localparam int MAX_FRAME_W = 64;

  // Bits of the frame that lie outside the data field; a 1 there means the ADC misbehaved.
  function automatic logic [MAX_FRAME_W-1:0] pad_mask(input int frame_w, input int data_w,
                                                      input int data_lsb);
    logic [MAX_FRAME_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FRAME_W; i++) begin
      if ((i < frame_w) && ((i < data_lsb) || (i >= data_lsb + data_w))) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Counter width able to hold 0..max_count, never narrower than one bit.
  function automatic int cnt_w(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Parameter sanity: field must fit in the frame and SCK needs at least two cycles per half.
  function automatic bit cfg_ok(input int frame_w, input int data_w, input int data_lsb,
                                input int clk_div, input int n_ch, input int quiet,
                                input int period);
    return (data_w >= 1) && (data_lsb >= 0) && (data_lsb + data_w <= frame_w) &&
           (frame_w >= 2) && (frame_w <= MAX_FRAME_W) && (clk_div >= 2) &&
           (n_ch >= 1) && (n_ch <= 8) && (quiet >= 2) && (period >= 1);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: low half then high half per bit, rise strobe at the end of each low half.
// Latency: sck drops in the first enabled cycle; last_o fires in the final cycle of bit FRAME_W-1.
// Backpressure: none; counters clear whenever en_i is low, so sck_o idles high.
module spi_sck_gen
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV = 500,
  parameter int FRAME_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic last_o
);

  localparam int DIV_W = cnt_w(CLK_DIV - 1);
  localparam int BIT_W = cnt_w(FRAME_W - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             phase_q, phase_d;   // 0 = low half, 1 = high half
  logic             half_end;

  assign half_end = (div_q == DIV_W'(CLK_DIV - 1));

  // The rising SCK edge coincides with the clk edge that closes the low half.
  assign sck_o  = ~en_i | phase_q;
  assign rise_o = en_i & ~phase_q & half_end;
  assign last_o = en_i & phase_q & half_end & (bit_q == BIT_W'(FRAME_W - 1));

  // Next-state for the half-period counter, phase and bit counter.
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    if (!en_i) begin
      div_d   = '0;
      bit_d   = '0;
      phase_d = 1'b0;
    end else if (half_end) begin
      div_d   = '0;
      phase_d = ~phase_q;
      if (phase_q) begin
        bit_d = bit_q + BIT_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_adc_scanner.sv
// Read-only SPI master scanning N_CH ADC chip selects; extracts a data field and flags pad bits.
// Latency: 1 + CLK_DIV*(2*FRAME_W+2) cycles from start/cont in IDLE to the valid_po pulse.
// Backpressure: none; start_pi outside IDLE is dropped, results are a one-cycle strobe.
module spi_adc_scanner
  import spi_adc_pkg::*;
#(
  parameter  int FRAME_W  = 16,
  parameter  int DATA_W   = 8,
  parameter  int DATA_LSB = 4,
  parameter  int N_CH     = 1,
  parameter  int CLK_DIV  = 500,
  parameter  int QUIET    = 50,
  parameter  int PERIOD   = 100000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic              start_pi,
  input  logic              cont_pi,
  input  logic              miso_pi,
  output logic              sck_po,
  output logic [N_CH-1:0]   cs_po,
  output logic              busy_po,
  output logic              valid_po,
  output logic [DATA_W-1:0] data_po,
  output logic [CH_W-1:0]   ch_po,
  output logic              pad_err_po
);

  if (!cfg_ok(FRAME_W, DATA_W, DATA_LSB, CLK_DIV, N_CH, QUIET, PERIOD)) begin : g_cfg_err
    $error("spi_adc_scanner: illegal parameter combination");
  end

  localparam int CNT_W = cnt_w((CLK_DIV > QUIET) ? CLK_DIV : QUIET);
  localparam int PER_W = cnt_w(PERIOD);
  localparam logic [FRAME_W-1:0] PAD_MASK = FRAME_W'(pad_mask(FRAME_W, DATA_W, DATA_LSB));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic               cont_q, cont_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CH_W-1:0]    chout_q, chout_d;
  logic               pad_q, pad_d;

  logic sck_rise, frame_last, div_last, per_due, frame_act;

  assign div_last  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign per_due   = (per_q >= PER_W'(PERIOD - 1));
  assign frame_act = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV),
    .FRAME_W(FRAME_W)
  ) u_sck_gen (
    .clk_i (clk_pi),
    .rst_i (rst_pi),
    .en_i  (state_q == ST_SHIFT),
    .sck_o (sck_po),
    .rise_o(sck_rise),
    .last_o(frame_last)
  );

  assign busy_po    = (state_q != ST_IDLE);
  assign valid_po   = (state_q == ST_DONE);
  assign data_po    = data_q;
  assign ch_po      = chout_q;
  assign pad_err_po = pad_q;

  // Only the selected channel's CS goes low, and only while a frame is on the wire.
  always_comb begin
    cs_po = '1;
    for (int i = 0; i < N_CH; i++) begin
      cs_po[i] = ~(frame_act && (ch_q == CH_W'(i)));
    end
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> QUIET -> (IDLE | SETUP).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    ch_d    = ch_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    chout_d = chout_q;
    pad_d   = pad_q;
    // Period counter saturates so a long frame cannot wrap it back below PERIOD-1.
    per_d   = per_due ? per_q : per_q + PER_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_pi || cont_pi) begin
          state_d = ST_SETUP;
          cont_d  = cont_pi;
          cnt_d   = '0;
          per_d   = '0;
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (sck_rise) begin
          shreg_d = {shreg_q[FRAME_W-2:0], miso_pi};
        end
        if (frame_last) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          data_d  = shreg_q[DATA_LSB +: DATA_W];
          pad_d   = |(shreg_q & PAD_MASK);
          chout_d = ch_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // CS is already high here, so DONE is the first cycle of the inter-frame gap.
        state_d = ST_QUIET;
        cnt_d   = CNT_W'(1);
        ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
      end
      ST_QUIET: begin
        if (cnt_q >= CNT_W'(QUIET - 1)) begin
          if (!cont_q) begin
            state_d = ST_IDLE;
          end else if (per_due) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            per_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins in every state, including mid-frame.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      cont_q  <= 1'b0;
      ch_q    <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      chout_q <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      cont_q  <= cont_d;
      ch_q    <= ch_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      chout_q <= chout_d;
      pad_q   <= pad_d;
    end
  end

endmodule
